// File: rtl/cpu_multicycle_seq_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle sequencer:
//   - RV64 major opcode constants used by the class decoder
//   - 3-bit sequencer state encoding (S_FETCH..S_TRAP), exported on the
//     debug state output
//   - instruction class encoding and the opcode -> class decode helper
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_ALU_R  = 7'b0110011;
   localparam logic [6:0] OP_ALU_I  = 7'b0010011;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CL_LOAD    = 3'd0,
      CL_STORE   = 3'd1,
      CL_BRANCH  = 3'd2,
      CL_ALU     = 3'd3,
      CL_ILLEGAL = 3'd4
   } class_t;

   // Map a major opcode onto the class that steers the sequencer.
   // Register- and immediate-form ALU ops share one class: the
   // sequencer treats them identically.
   function automatic class_t decode_class(input logic [6:0] op);
      class_t cl;
      case (op)
         OP_LOAD:            cl = CL_LOAD;
         OP_STORE:           cl = CL_STORE;
         OP_BRANCH:          cl = CL_BRANCH;
         OP_ALU_R, OP_ALU_I: cl = CL_ALU;
         default:            cl = CL_ILLEGAL;
      endcase
      return cl;
   endfunction

endpackage

// File: rtl/cpu_multicycle_seq_if.sv
// ----------------------------------------------------------------------------
// cpu_multicycle_seq_if
// Bundle of every sequencer control / handshake signal.
//   master : the sequencer (drives requests, enables, debug state, trap)
//   slave  : the datapath and memories (drive opcode, alu_zero, readys)
//
// Handshake: a request (imem_req / dmem_req) rises in the first cycle of
// FETCH / MEMORY and stays high, unchanged, through the cycle in which the
// matching ready is 1; that cycle completes the transfer. A ready seen
// while the matching request is low means nothing and is ignored. A
// request may be dropped without ready on timeout (-> trap) or reset.
// ----------------------------------------------------------------------------
interface cpu_multicycle_seq_if;

   logic [6:0] opcode;      // instr[6:0], valid from DECODE onward
   logic       alu_zero;    // ALU zero flag, valid in EXECUTE
   logic       imem_req;    // instruction fetch request
   logic       imem_ready;  // fetch complete, instruction valid
   logic       dmem_req;    // data memory request
   logic       dmem_we;     // 1 = store, 0 = load (with dmem_req)
   logic       dmem_ready;  // data access complete
   logic       ir_we;       // latch instruction register
   logic       pc_we;       // update PC (one instruction retires)
   logic       pc_sel;      // 0 = PC+4, 1 = branch target
   logic       rf_we;       // register file write enable
   logic       mem_to_reg;  // writeback source: 1 = load data
   logic [2:0] state;       // debug: current state encoding
   logic       trap;        // sticky fault flag

   modport master (
      input  opcode, alu_zero, imem_ready, dmem_ready,
      output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
             rf_we, mem_to_reg, state, trap
   );

   modport slave (
      output opcode, alu_zero, imem_ready, dmem_ready,
      input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
             rf_we, mem_to_reg, state, trap
   );

endinterface

// File: rtl/cpu_multicycle_seq_wait_timer.sv
// ----------------------------------------------------------------------------
// seq_wait_timer
// Counts cycles spent waiting on a memory handshake.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   clr      : clear the count (state change)
//   inc      : one more wait cycle
//   expired  : count has reached MAX_WAIT (never asserted if MAX_WAIT = 0)
// The counter is ceil(log2(MAX_WAIT+1)) bits and saturates at MAX_WAIT,
// so it can never wrap back below the limit.
// ----------------------------------------------------------------------------
module seq_wait_timer #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   // A zero limit still needs a legal (1-bit) vector; it simply never counts.
   localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CW-1:0] LP_MAX = CW'(MAX_WAIT);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != LP_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      expired = (MAX_WAIT != 0) && (r_cnt == LP_MAX);
   end

endmodule

// File: rtl/cpu_multicycle_seq.sv
// ----------------------------------------------------------------------------
// cpu_multicycle_seq
// Multi-cycle sequencer for the RV64 core: picks which of the shared-
// datapath stages (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK) runs each cycle,
// handshakes with variable-latency instruction/data memories, skips MEMORY
// for non-memory instructions and traps on illegal opcodes or on a memory
// handshake that exceeds MAX_WAIT cycles.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; all outputs read 0 while high
//   bus          cpu_multicycle_seq_if.master (opcode, alu_zero, readys in;
//                requests, enables, debug state, trap out)
//   cycle_count  [WIDTH] cycles not in TRAP     (CPU_SEQ_PERF_CNT_EN only)
//   instret      [WIDTH] retired instructions   (CPU_SEQ_PERF_CNT_EN only)
//
// Optional feature macro: CPU_SEQ_PERF_CNT_EN adds the two performance
// counters; without it the ports and counters do not exist.
//
// Outputs are combinational decodes of state, latched class and the ready
// inputs, so a ready completes its transfer in the same cycle it arrives.
// ----------------------------------------------------------------------------
module cpu_multicycle_seq
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   cpu_multicycle_seq_if.master bus
`ifdef CPU_SEQ_PERF_CNT_EN
   ,
   output logic [WIDTH-1:0]     cycle_count,
   output logic [WIDTH-1:0]     instret
`endif
);

   if (WIDTH == 0) begin : g_bad_width
      $error("cpu_multicycle_seq: WIDTH must be at least 1");
   end

   state_t r_state;
   state_t w_next_state;
   class_t r_class;
   class_t w_dec_class;
   logic   w_expired;
   logic   w_tmr_inc;
   logic   w_tmr_clr;
   logic   w_pc_we;

   always_comb begin
      w_dec_class = decode_class(bus.opcode);
   end

   // ------------------------------------------------------------------
   // Next-state logic. Ready is checked before the timeout so a transfer
   // completing in the last allowed cycle is never turned into a trap.
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_tmr_inc    = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (bus.imem_ready)  w_next_state = S_DECODE;
            else if (w_expired)  w_next_state = S_TRAP;
            else                 w_tmr_inc    = 1'b1;
         end
         S_DECODE: begin
            w_next_state = (w_dec_class == CL_ILLEGAL) ? S_TRAP : S_EXECUTE;
         end
         S_EXECUTE: begin
            case (r_class)
               CL_BRANCH:          w_next_state = S_FETCH;
               CL_ALU:             w_next_state = S_WRITEBACK;
               CL_LOAD, CL_STORE:  w_next_state = S_MEMORY;
               default:            w_next_state = S_TRAP;
            endcase
         end
         S_MEMORY: begin
            if (bus.dmem_ready)
               w_next_state = (r_class == CL_STORE) ? S_FETCH : S_WRITEBACK;
            else if (w_expired)
               w_next_state = S_TRAP;
            else
               w_tmr_inc = 1'b1;
         end
         S_WRITEBACK: w_next_state = S_FETCH;
         S_TRAP:      w_next_state = S_TRAP;
         default:     w_next_state = S_TRAP;
      endcase
   end

   // Every state change starts a fresh wait window.
   always_comb begin
      w_tmr_clr = (w_next_state != r_state);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_class <= CL_ILLEGAL;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_DECODE) r_class <= w_dec_class;
      end
   end

   seq_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_tmr_clr),
      .inc     (w_tmr_inc),
      .expired (w_expired)
   );

   // ------------------------------------------------------------------
   // Output decode. Everything reads 0 during reset, including the debug
   // state, so an abandoned memory request disappears immediately.
   // ------------------------------------------------------------------
   always_comb begin
      bus.imem_req   = 1'b0;
      bus.dmem_req   = 1'b0;
      bus.dmem_we    = 1'b0;
      bus.ir_we      = 1'b0;
      w_pc_we        = 1'b0;
      bus.pc_sel     = 1'b0;
      bus.rf_we      = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.trap       = 1'b0;
      bus.state      = S_FETCH;
      if (!rst) begin
         bus.state = r_state;
         case (r_state)
            S_FETCH: begin
               bus.imem_req = 1'b1;
               bus.ir_we    = bus.imem_ready;
            end
            S_EXECUTE: begin
               if (r_class == CL_BRANCH) begin
                  w_pc_we    = 1'b1;
                  bus.pc_sel = bus.alu_zero;
               end
            end
            S_MEMORY: begin
               bus.dmem_req = 1'b1;
               bus.dmem_we  = (r_class == CL_STORE);
               // A store retires as soon as its write is accepted.
               if (bus.dmem_ready && (r_class == CL_STORE)) w_pc_we = 1'b1;
            end
            S_WRITEBACK: begin
               bus.rf_we      = 1'b1;
               bus.mem_to_reg = (r_class == CL_LOAD);
               w_pc_we        = 1'b1;
            end
            S_TRAP: bus.trap = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.pc_we = w_pc_we;
   end

`ifdef CPU_SEQ_PERF_CNT_EN
   logic [WIDTH-1:0] r_cycle_count;
   logic [WIDTH-1:0] r_instret;

   // Both counters wrap naturally at 2^WIDTH; a retire is any pc_we cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycle_count <= '0;
         r_instret     <= '0;
      end else begin
         if (r_state != S_TRAP) r_cycle_count <= r_cycle_count + 1'b1;
         if (w_pc_we)           r_instret     <= r_instret + 1'b1;
      end
   end

   always_comb begin
      cycle_count = r_cycle_count;
      instret     = r_instret;
   end
`endif

endmodule

// File: doc/cpu_multicycle_seq.md
Name: cpu_multicycle_seq

Overview:
Multi-cycle sequencer for the next-generation RV64 core. IF/ID/EX/MEM/WB become registered stages that share one datapath, and this block decides which stage is enabled each cycle. It handles variable-latency instruction and data memories through a req/ready handshake, skips the MEM step for instructions that do not access memory, and traps on illegal opcodes or memory timeouts.

Parameters:
WIDTH, 64, datapath width; sets the width of the performance counters.
MAX_WAIT, 15, maximum wait cycles for a memory handshake before trapping; 0 disables the timeout.

Ports:
clk  in  1  clock; everything is rising-edge.
rst  in  1  synchronous, active-high reset.
opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward.
alu_zero  in  1  ALU zero flag, valid in EXECUTE.
imem_req  out  1  instruction fetch request.
imem_ready  in  1  fetch complete; instruction data is valid this cycle.
dmem_req  out  1  data memory request.
dmem_we  out  1  1 = store, 0 = load; meaningful only while dmem_req = 1.
dmem_ready  in  1  data access complete.
ir_we  out  1  latch the instruction register.
pc_we  out  1  update the PC.
pc_sel  out  1  0 = PC+4, 1 = branch target.
rf_we  out  1  register file write enable.
mem_to_reg  out  1  writeback source: 1 = load data, 0 = ALU result.
state  out  3  current state encoding, for debug.
trap  out  1  sticky fault flag.

Behaviour:
- Outputs: all outputs are combinational decodes of state, class and the ready inputs. All outputs are forced to 0 while rst = 1.
- Reset: state = FETCH, class = ILLEGAL, wait counter = 0, trap = 0.
- Class decode (registered in DECODE):
  - 0000011 → LOAD
  - 0100011 → STORE
  - 1100011 → BRANCH (BEQ semantics)
  - 0110011 or 0010011 → ALU
  - anything else → ILLEGAL
- FETCH (0):
  - imem_req = 1.
  - When imem_ready = 1: ir_we = 1 and go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE (1):
  - Register the class.
  - ILLEGAL → TRAP; otherwise go to EXECUTE.
- EXECUTE (2):
  - BRANCH: pc_we = 1, pc_sel = alu_zero, then FETCH.
  - ALU: go to WRITEBACK.
  - LOAD or STORE: go to MEMORY.
- MEMORY (3):
  - dmem_req = 1; dmem_we = 1 for STORE, 0 for LOAD.
  - On dmem_ready = 1, STORE: pc_we = 1, pc_sel = 0, then FETCH.
  - On dmem_ready = 1, LOAD: go to WRITEBACK.
  - Otherwise wait and increment the wait counter.
- WRITEBACK (4):
  - rf_we = 1, mem_to_reg = (class == LOAD), pc_we = 1, pc_sel = 0.
  - Then FETCH.
- TRAP (5):
  - trap = 1; all enables and requests are 0.
  - The only exit is rst.
- Cycle counts with ready asserted in the first cycle: BRANCH 3, ALU 4, STORE 4, LOAD 5.
- Request hold rule:
  - imem_req and dmem_req stay high, unchanged, from the first request cycle through the ready cycle.
  - A ready input seen while no request is outstanding is ignored.
- Timeout:
  - The wait counter is ceil(log2(MAX_WAIT+1)) bits wide and clears on every state change.
  - If MAX_WAIT > 0 and the counter equals MAX_WAIT with ready still 0, go to TRAP on the next edge and drop the request.
  - If ready arrives in that same cycle, the handshake completes normally; ready wins over timeout.
- Retire: an instruction retires on any cycle with pc_we = 1.
- Reset mid-operation: rst overrides every state, including MEMORY with a request outstanding. The memory side must tolerate the request being abandoned.

Optional Feature:
Macro: CPU_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output ports cycle_count [WIDTH-1:0] and instret [WIDTH-1:0]; both reset to 0.
  - cycle_count increments every cycle with rst = 0 except in TRAP.
  - instret increments on each retire.
  - Both wrap modulo 2^WIDTH.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

Decomposition:
- Package cpu_pkg:
  - opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_ALU_R, OP_ALU_I;
  - state encoding S_FETCH..S_TRAP (3 bits);
  - class encoding (LOAD, STORE, BRANCH, ALU, ILLEGAL).
- Sub-module seq_wait_timer: parametrised by MAX_WAIT; inputs clr and inc; output expired. This is the natural single split.

Test Plan:
- Zero-wait R-type (opcode 0110011), imem_ready and dmem_ready tied to 1 → states 0,1,2,4,0; rf_we = 1 for exactly 1 cycle; 4 cycles per instruction.
- LOAD with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles with dmem_we = 0; then WRITEBACK with mem_to_reg = 1; 8 cycles total.
- BEQ with alu_zero = 1, then BEQ with alu_zero = 0 → pc_we = 1 in EXECUTE with pc_sel = 1, then pc_sel = 0; 3 cycles each; rf_we never asserted.
- imem_ready held 0 with MAX_WAIT = 15 → TRAP after 16 FETCH cycles; trap stays 1 until rst. Repeat with ready at cycle 16 → normal DECODE, no trap.
- Opcode 1111111 → DECODE then TRAP; rst mid-MEMORY with dmem_req high → next cycle in FETCH, dmem_req = 0.
- CPU_SEQ_PERF_CNT_EN defined, 10 ALU instructions at zero wait → instret = 10, cycle_count = 40.
